db9_joy_deserializer: RTL

- Drives the DB9/JAMMA 74HC165 shift-register chain on the ZXTRES joystick connector: generates joy_load_n and joy_clk, and samples joy_data.
- Deserializes one 16-bit frame per scan into two active-high 8-bit joystick words.
- Sits directly downstream of the connector pins and replaces the raw pin passthrough at board top level.
- Its outputs feed the core's joystick inputs.

---
 rtl/db9_joy_deserializer_if.sv | 28 ++
 rtl/db9_joy_deserializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/db9_joy_deserializer_if.sv
// Pin and output bundle between the DB9/JAMMA 74HC165 chain and the joystick deserializer.
// master = deserializer side, slave = connector/consumer side.
interface db9_joy_deserializer_if;
  logic       joy_clk;
  logic       joy_load_n;
  logic       joy_data;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic       frame_valid;

  modport master (
    output joy_clk,
    output joy_load_n,
    input  joy_data,
    output joy1,
    output joy2,
    output frame_valid
  );

  modport slave (
    input  joy_clk,
    input  joy_load_n,
    output joy_data,
    input  joy1,
    input  joy2,
    input  frame_valid
  );
endinterface

// File: rtl/db9_joy_deserializer.sv
// Scans the ZXTRES DB9/JAMMA 74HC165 chain and deserializes each 16-bit frame into two active-high sticks.
// Define DB9_JOY_DEBOUNCE_EN to require two agreeing frames before an output bit changes.
module db9_joy_deserializer #(
  parameter int CLKDIV = 50,
  parameter int NBITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  db9_joy_deserializer_if.master joy
);

  localparam int            CW       = $clog2(NBITS);
  localparam logic [15:0]   DIV_LAST = 16'(CLKDIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    LOAD,
    SAMPLE,
    CLKHI
  } state_t;

  state_t           state;
  logic [15:0]      divider;
  logic [CW-1:0]    bit_cnt;
  logic [NBITS-1:0] shift_reg;
  logic             joy_data_q;
  logic             tick;
  logic             sample_bit;
  logic [NBITS-1:0] frame_new;
  logic [NBITS-1:0] frame_out;

  assign tick      = (divider == DIV_LAST);
  // With a single-cycle tick there is no slack for an extra register stage.
  assign sample_bit = (CLKDIV >= 2) ? joy_data_q : joy.joy_data;
  assign frame_new = ~shift_reg;

`ifdef DB9_JOY_DEBOUNCE_EN
  logic [NBITS-1:0] hist;
  logic [NBITS-1:0] agree;

  assign agree     = ~(frame_new ^ hist);
  assign frame_out = (frame_new & agree) | ({joy.joy1, joy.joy2} & ~agree);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
    end else if (tick && (state == CLKHI) && (bit_cnt == CNT_LAST)) begin
      hist <= frame_new;
    end
  end
`else
  assign frame_out = frame_new;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= LOAD;
      divider         <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      joy_data_q      <= 1'b0;
      joy.joy_clk     <= 1'b0;
      joy.joy_load_n  <= 1'b1;
      joy.joy1        <= '0;
      joy.joy2        <= '0;
      joy.frame_valid <= 1'b0;
    end else begin
      joy_data_q      <= joy.joy_data;
      joy.frame_valid <= 1'b0;
      divider         <= tick ? '0 : divider + 1'b1;
      if (tick) begin
        case (state)
          LOAD: begin
            joy.joy_load_n <= 1'b0;
            joy.joy_clk    <= 1'b0;
            bit_cnt        <= '0;
            state          <= SAMPLE;
          end
          SAMPLE: begin
            joy.joy_load_n <= 1'b1;
            joy.joy_clk    <= 1'b0;
            shift_reg      <= {shift_reg[NBITS-2:0], sample_bit};
            state          <= CLKHI;
          end
          CLKHI: begin
            joy.joy_clk <= 1'b1;
            if (bit_cnt != CNT_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= SAMPLE;
            end else begin
              joy.joy1        <= frame_out[15:8];
              joy.joy2        <= frame_out[7:0];
              joy.frame_valid <= 1'b1;
              state           <= LOAD;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule
